// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine and CPU/DMA time-slicing of the shared memory ports.
// A write to 0xFF46 copies OAM_BYTES bytes from {val,8'h00} to 0xFE00.
// During the copy the CPU may only touch HRAM (0xFF80-0xFFFE).
module oam_dma_arbiter #(
  parameter int unsigned CYCLES_PER_BYTE = 4,
  parameter int unsigned START_DELAY     = 4,
  parameter int unsigned OAM_BYTES       = 160
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_cpu_rd_addr,
  input  logic        i_cpu_wr_en,
  input  logic [15:0] i_cpu_wr_addr,
  input  logic [7:0]  i_cpu_wr_data,
  output logic [7:0]  o_cpu_rd_data,
  output logic        o_cpu_wait,
  output logic [15:0] o_mem_rd_addr,
  output logic        o_mem_wr_en,
  output logic [15:0] o_mem_wr_addr,
  output logic [7:0]  o_mem_wr_data,
  input  logic [7:0]  i_mem_rd_data,
  output logic        o_dma_active
);

  localparam int unsigned PW = $clog2(CYCLES_PER_BYTE);
  localparam int unsigned DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  localparam logic [PW-1:0] LAST_PHASE = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0]    LAST_IDX   = 8'(OAM_BYTES - 1);
  localparam logic [DW-1:0] DELAY_INIT = DW'(START_DELAY - 1);
  localparam logic [15:0]   DMA_REG    = 16'hFF46;
  localparam logic [15:0]   OAM_BASE   = 16'hFE00;

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    src_hi_q, src_hi_d;
  logic [7:0]    idx_q, idx_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [DW-1:0] delay_q, delay_d;
  logic          ff_force_q, ff_force_d;

  logic rd_hram;
  logic wr_hram;
  logic ff46_wr;

  // Address decode of the current CPU access.
  always_comb begin
    rd_hram = (i_cpu_rd_addr >= 16'hFF80) && (i_cpu_rd_addr != 16'hFFFF);
    wr_hram = (i_cpu_wr_addr >= 16'hFF80) && (i_cpu_wr_addr != 16'hFFFF);
    ff46_wr = i_cpu_wr_en && (i_cpu_wr_addr == DMA_REG);
  end

  // Blocked non-HRAM reads during a transfer return 0xFF on the next cycle.
  assign o_cpu_rd_data = ff_force_q ? 8'hFF : i_mem_rd_data;

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      src_hi_q   <= '0;
      idx_q      <= '0;
      phase_q    <= '0;
      delay_q    <= '0;
      ff_force_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_hi_q   <= src_hi_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      delay_q    <= delay_d;
      ff_force_q <= ff_force_d;
    end
  end

  // Next-state logic and memory-port steering.
  always_comb begin
    state_d       = state_q;
    src_hi_d      = src_hi_q;
    idx_d         = idx_q;
    phase_d       = phase_q;
    delay_d       = delay_q;
    ff_force_d    = 1'b0;
    o_cpu_wait    = 1'b0;
    o_dma_active  = 1'b0;
    o_mem_rd_addr = i_cpu_rd_addr;
    o_mem_wr_en   = i_cpu_wr_en;
    o_mem_wr_addr = i_cpu_wr_addr;
    o_mem_wr_data = i_cpu_wr_data;

    unique case (state_q)
      IDLE: begin
        if (ff46_wr) begin
          src_hi_d = i_cpu_wr_data;
          delay_d  = DELAY_INIT;
          state_d  = START;
        end
      end

      START: begin
        o_dma_active = 1'b1;
        // A fresh FF46 write wins over the delay expiring in the same cycle.
        if (ff46_wr) begin
          src_hi_d = i_cpu_wr_data;
          delay_d  = DELAY_INIT;
        end else if (delay_q == '0) begin
          state_d = XFER;
          idx_d   = '0;
          phase_d = '0;
        end else begin
          delay_d = delay_q - DW'(1);
        end
      end

      XFER: begin
        o_dma_active = 1'b1;
        ff_force_d   = !rd_hram;
        o_mem_wr_en  = i_cpu_wr_en && wr_hram;
        if (phase_q == '0) begin
          o_mem_rd_addr = {src_hi_q, idx_q};
          o_cpu_wait    = rd_hram;
        end else if (phase_q == PW'(1)) begin
          o_mem_wr_en   = 1'b1;
          o_mem_wr_addr = OAM_BASE + {8'h00, idx_q};
          o_mem_wr_data = i_mem_rd_data;
          o_cpu_wait    = i_cpu_wr_en && wr_hram;
        end

        if (phase_q == LAST_PHASE) begin
          phase_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Reset aborts at once, including the write of the current cycle.
    if (i_rst) o_mem_wr_en = 1'b0;
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: directed scenarios plus random
// CPU traffic, compared against a schedule-based reference model.
module tb_oam_dma_arbiter;

  localparam int CPB  = 4;
  localparam int SD   = 4;
  localparam int NB   = 160;
  localparam int XLEN = NB * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_rd_addr;
  logic        cpu_wr_en;
  logic [15:0] cpu_wr_addr;
  logic [7:0]  cpu_wr_data;
  logic [7:0]  cpu_rd_data;
  logic        cpu_wait;
  logic [15:0] mem_rd_addr;
  logic        mem_wr_en;
  logic [15:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic [7:0]  mem_q;
  logic        dma_active;

  always #5 clk = ~clk;

  oam_dma_arbiter #(
    .CYCLES_PER_BYTE(CPB),
    .START_DELAY    (SD),
    .OAM_BYTES      (NB)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cpu_rd_addr(cpu_rd_addr),
    .i_cpu_wr_en  (cpu_wr_en),
    .i_cpu_wr_addr(cpu_wr_addr),
    .i_cpu_wr_data(cpu_wr_data),
    .o_cpu_rd_data(cpu_rd_data),
    .o_cpu_wait   (cpu_wait),
    .o_mem_rd_addr(mem_rd_addr),
    .o_mem_wr_en  (mem_wr_en),
    .o_mem_wr_addr(mem_wr_addr),
    .o_mem_wr_data(mem_wr_data),
    .i_mem_rd_data(mem_q),
    .o_dma_active (dma_active)
  );

  // Environment memory (driven by the DUT) and the reference image.
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: transfer schedule is pure arithmetic on cycles.
  int         cyc = 0;
  int         go = -1;
  int         wr_cyc = 0;
  logic [7:0] src = '0;
  logic [7:0] dma_byte = '0;
  logic [7:0] exp_rd = '0;
  bit         exp_rd_valid = 1'b0;
  bit         last_wait = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit hram(input logic [15:0] a);
    return (a >= 16'hFF80) && (a <= 16'hFFFE);
  endfunction

  function automatic logic [15:0] pick_addr();
    int unsigned r;
    r = $urandom_range(0, 15);
    case (r)
      0, 1, 2, 3, 4: return 16'hFF80 + 16'($urandom_range(0, 126));
      5:             return 16'hFFFF;
      6:             return 16'hFF7F;
      7:             return 16'hFF46;
      8, 9, 10:      return 16'hC000 + 16'($urandom_range(0, 255));
      11:            return 16'h0150;
      12:            return 16'hFE00 + 16'($urandom_range(0, 159));
      default:       return 16'($urandom);
    endcase
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic cycle(input logic r, input logic [15:0] ra, input logic we,
                       input logic [15:0] wa, input logic [7:0] wd, input bit chk);
    bit          xfer, strt, e_wait, e_wen;
    int          k, ph;
    logic [7:0]  idx, e_wdata, lat_wd;
    logic [15:0] e_waddr, lat_ra, lat_wa;
    logic        lat_we;
    @(negedge clk);
    rst         = r;
    cpu_rd_addr = ra;
    cpu_wr_en   = we;
    cpu_wr_addr = wa;
    cpu_wr_data = wd;
    #1;
    xfer   = (go >= 0) && (cyc >= go) && (cyc < go + XLEN);
    strt   = (go >= 0) && (cyc > wr_cyc) && (cyc < go);
    k      = xfer ? cyc - go : 0;
    idx    = 8'(k / CPB);
    ph     = k % CPB;
    e_wait = xfer && ((hram(ra) && ph == 0) || (we && hram(wa) && ph == 1));
    e_wen   = we;
    e_waddr = wa;
    e_wdata = wd;
    if (xfer && ph == 1) begin
      e_wen   = 1'b1;
      e_waddr = 16'hFE00 + {8'h00, idx};
      e_wdata = dma_byte;
    end else if (xfer) begin
      e_wen = we && hram(wa);
    end
    if (r) e_wen = 1'b0;

    if (chk) begin
      check("dma_active", 32'(dma_active), 32'(xfer || strt));
      check("cpu_wait", 32'(cpu_wait), 32'(e_wait));
      check("mem_wr_en", 32'(mem_wr_en), 32'(e_wen));
      if (e_wen) begin
        check("mem_wr_addr", 32'(mem_wr_addr), 32'(e_waddr));
        check("mem_wr_data", 32'(mem_wr_data), 32'(e_wdata));
      end
      if (exp_rd_valid) check("cpu_rd_data", 32'(cpu_rd_data), 32'(exp_rd));
    end
    last_wait = e_wait;

    if (r) begin
      exp_rd_valid = 1'b0;
    end else begin
      exp_rd_valid = 1'b1;
      if (xfer && !hram(ra))  exp_rd = 8'hFF;
      else if (xfer && ph == 0) exp_rd = ref_mem[{src, idx}];
      else                      exp_rd = ref_mem[ra];
    end
    if (xfer && ph == 0) dma_byte = ref_mem[{src, idx}];
    if (e_wen) ref_mem[e_waddr] = e_wdata;
    if (r) begin
      go = -1;
    end else if (!xfer && we && wa == 16'hFF46) begin
      src    = wd;
      wr_cyc = cyc;
      go     = cyc + SD + 1;
    end

    lat_ra = mem_rd_addr;
    lat_we = mem_wr_en;
    lat_wa = mem_wr_addr;
    lat_wd = mem_wr_data;
    @(posedge clk);
    mem_q <= mem[lat_ra];
    if (lat_we) mem[lat_wa] <= lat_wd;
    cyc++;
  endtask

  initial begin
    logic [15:0] ra, wa;
    logic [7:0]  wd, v;
    logic        we;
    bit          hold;
    int          diffs;
    logic [7:0]  snap [0:NB-1];
    logic [7:0]  srcsnap [0:NB-1];

    for (int i = 0; i < 65536; i++) begin
      v          = 8'($urandom);
      mem[i]    <= v;
      ref_mem[i] = v;
    end
    mem_q <= '0;

    // Reset: first cycle unchecked (state still unknown), then checked.
    cycle(1'b1, 16'h0000, 1'b0, 16'h0000, 8'h00, 1'b0);
    cycle(1'b1, 16'h0000, 1'b0, 16'h0000, 8'h00, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00, 1'b1);
    check("rst_dma_active", 32'(dma_active), 32'd0);
    check("rst_cpu_wait", 32'(cpu_wait), 32'd0);

    // Plain pass-through write then read.
    cycle(1'b0, 16'h0000, 1'b1, 16'hC000, 8'h5A, 1'b1);
    cycle(1'b0, 16'hC000, 1'b0, 16'h0000, 8'h00, 1'b1);
    #2;
    check("rd_c000", 32'(cpu_rd_data), 32'h5A);
    check("idle_dma_active", 32'(dma_active), 32'd0);

    // Preload source page C0 with its index.
    for (int i = 0; i < NB; i++)
      cycle(1'b0, 16'h0000, 1'b1, 16'hC000 + 16'(i), 8'(i), 1'b1);

    // Transfer from C0 with CPU traffic; the CPU holds its access on wait.
    cycle(1'b0, 16'h0000, 1'b1, 16'hFF46, 8'hC0, 1'b1);
    hold = 1'b0;
    ra = '0; we = 1'b0; wa = '0; wd = '0;
    for (int j = 1; j < 660; j++) begin
      if (!hold) begin
        ra = (j % 7 == 0) ? 16'hFF90 : 16'h0150;
        we = (j % 11 == 0) || (j == 20);
        wa = (j == 20) ? 16'hC000 : 16'hFFA0;
        wd = (j == 20) ? 8'h12 : 8'(j);
      end
      cycle(1'b0, ra, we, wa, wd, 1'b1);
      hold = last_wait;
    end
    for (int i = 0; i < NB; i++) check("oam_copy_c0", 32'(mem[16'hFE00 + 16'(i)]), 32'(i));
    check("c000_untouched", 32'(mem[16'hC000]), 32'h00);

    // Restart in START: source switches to D0.
    for (int i = 0; i < NB; i++) srcsnap[i] = mem[16'hD000 + 16'(i)];
    cycle(1'b0, 16'h0000, 1'b1, 16'hFF46, 8'hC0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1, 16'hFF46, 8'hD0, 1'b1);
    for (int j = 0; j < 644; j++) cycle(1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00, 1'b1);
    for (int i = 0; i < NB; i++) check("oam_copy_d0", 32'(mem[16'hFE00 + 16'(i)]), 32'(srcsnap[i]));

    // FF46 write on the first IDLE cycle, then reset at idx 50 phase 1.
    for (int i = 0; i < NB; i++) begin
      snap[i]    = mem[16'hFE00 + 16'(i)];
      srcsnap[i] = mem[16'hC100 + 16'(i)];
    end
    cycle(1'b0, 16'h0000, 1'b1, 16'hFF46, 8'hC1, 1'b1);
    for (int j = 0; j < 205; j++) cycle(1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00, 1'b1);
    cycle(1'b1, 16'h0000, 1'b0, 16'h0000, 8'h00, 1'b1);
    for (int j = 0; j < 3; j++) cycle(1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00, 1'b1);
    for (int i = 0; i < 50; i++) check("oam_partial", 32'(mem[16'hFE00 + 16'(i)]), 32'(srcsnap[i]));
    for (int i = 50; i < NB; i++) check("oam_kept", 32'(mem[16'hFE00 + 16'(i)]), 32'(snap[i]));

    // Random CPU traffic with hold-on-wait behaviour.
    hold = 1'b0;
    for (int n = 0; n < 8000; n++) begin
      if (!hold) begin
        ra = pick_addr();
        we = ($urandom_range(0, 2) == 0);
        wa = pick_addr();
        wd = 8'($urandom);
      end
      cycle(1'b0, ra, we, wa, wd, 1'b1);
      hold = last_wait;
    end
    for (int j = 0; j < 700; j++) cycle(1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00, 1'b1);

    #2;
    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_image_diffs", 32'(diffs), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
